// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Loads one configuration image into a downstream scan-style configuration
// chain. Bitstream words arrive on a valid/ready stream, are serialised
// MSB-first onto the chain head, and the chain is shifted exactly CHAIN_LEN
// times. The bits that fall out of the chain tail (the previous image) are
// folded into a CRC-16 so software can check what was overwritten.
//
// Ports:
//   prog_clk       configuration clock (only clock)
//   prog_reset_n   asynchronous active-low reset
//   start          begin a load (honoured in IDLE or DONE only)
//   abort          terminate a load / leave DONE, back to IDLE
//   cfg_data       bitstream word, bit DATA_W-1 shifted first
//   cfg_valid      cfg_data is valid
//   cfg_ready      loader takes cfg_data this cycle
//   ccff_head      registered serial bit into the chain head
//   ccff_shift_en  registered chain shift enable
//   ccff_tail      serial bit out of the chain tail
//   busy           a load is in progress (LOAD)
//   done           load completed (DONE)
//   bits_shifted   bits presented on ccff_head in the current load
//   readback_crc   CRC-16 (poly 0x1021, init 0xFFFF) of the tail bits
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
    parameter int DATA_W    = 32,
    parameter int CHAIN_LEN = 16,
    localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  bits_shifted,
    output logic [15:0]       readback_crc
);

    localparam int BCW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX_C  = CNT_W'(CHAIN_LEN - 1);
    localparam logic [BCW-1:0]   WORD_REM_C  = BCW'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-2:0] shift_buf_q;  // bits still to present, MSB next
    logic [BCW-1:0]    buf_cnt_q;    // valid bits left in shift_buf_q
    logic [CNT_W-1:0]  bits_q;
    logic [15:0]       crc_q;
    logic [15:0]       crc_next;
    logic              crc_fb;
    logic              head_q;
    logic              shift_en_q;

    logic start_go;
    logic accept;
    logic final_shift;
    logic last_bit;
    logic have_bit;

    // Stream handshake: a word transfers on any prog_clk edge where
    // cfg_valid && cfg_ready. cfg_ready depends only on loader state, never
    // on cfg_valid, and the producer must hold cfg_data stable while
    // cfg_valid is high and cfg_ready is low.
    assign start_go    = start && !abort && (state_q != S_LOAD);
    assign accept      = cfg_valid && cfg_ready;
    // The last bit is already on the head and this edge shifts it in.
    assign final_shift = (state_q == S_LOAD) && (bits_q == CHAIN_LEN_C) && shift_en_q;
    // The bit about to be presented is the chain's last one.
    assign last_bit    = (bits_q == LAST_IDX_C);
    assign have_bit    = (buf_cnt_q != '0) && (bits_q < CHAIN_LEN_C);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_go) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (abort)            state_d = S_IDLE;
                else if (final_shift) state_d = S_DONE;
            end
            S_DONE: begin
                if (abort)         state_d = S_IDLE;
                else if (start_go) state_d = S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        cfg_ready = 1'b0;
        case (state_q)
            S_LOAD: begin
                busy      = 1'b1;
                cfg_ready = (buf_cnt_q == '0) && (bits_q < CHAIN_LEN_C);
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // ---------------- readback CRC-16 ----------------
    always_comb begin
        crc_fb   = crc_q[15] ^ ccff_tail;
        crc_next = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
    end

    // ---------------- serialiser datapath ----------------
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shift_buf_q <= '0;
            buf_cnt_q   <= '0;
            bits_q      <= '0;
            crc_q       <= 16'hFFFF;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
        end else begin
            // Every edge with the enable high shifts the chain, so the tail
            // bit is consumed regardless of what else happens on this edge.
            if (start_go) begin
                crc_q <= 16'hFFFF;
            end else if (shift_en_q) begin
                crc_q <= crc_next;
            end

            if (abort) begin
                // bits_q is left as-is so software can see how far it got.
                shift_en_q <= 1'b0;
                buf_cnt_q  <= '0;
            end else if (start_go) begin
                bits_q     <= '0;
                buf_cnt_q  <= '0;
                shift_en_q <= 1'b0;
            end else if (state_q == S_LOAD) begin
                if (final_shift) begin
                    shift_en_q <= 1'b0;
                end else if (accept) begin
                    head_q      <= cfg_data[DATA_W-1];
                    shift_buf_q <= cfg_data[DATA_W-2:0];
                    // Surplus bits of the word beyond the chain are dropped.
                    buf_cnt_q   <= last_bit ? '0 : WORD_REM_C;
                    shift_en_q  <= 1'b1;
                    bits_q      <= bits_q + CNT_W'(1);
                end else if (have_bit) begin
                    head_q      <= shift_buf_q[DATA_W-2];
                    shift_buf_q <= shift_buf_q << 1;
                    buf_cnt_q   <= last_bit ? '0 : (buf_cnt_q - BCW'(1));
                    shift_en_q  <= 1'b1;
                    bits_q      <= bits_q + CNT_W'(1);
                end else begin
                    // Starved: hold the head bit, stop the chain.
                    shift_en_q <= 1'b0;
                end
            end
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign bits_shifted  = bits_q;
    assign readback_crc  = crc_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//
// Directed bench for ccff_bitstream_loader with DATA_W=8, CHAIN_LEN=12.
// A small behavioural model of the configuration chain sits on the outputs
// so the tail carries the previously loaded image back into the loader.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

    localparam int DW = 8;
    localparam int CL = 12;
    localparam int CW = $clog2(CL + 1);

    // ---------------- clock / reset ----------------
    logic prog_clk     = 1'b0;
    logic prog_reset_n = 1'b0;
    always #5 prog_clk = ~prog_clk;

    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [DW-1:0] cfg_data  = '0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic          ccff_head;
    logic          ccff_shift_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic [CW-1:0] bits_shifted;
    logic [15:0]   readback_crc;

    ccff_bitstream_loader #(
        .DATA_W    (DW),
        .CHAIN_LEN (CL)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .abort         (abort),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .bits_shifted  (bits_shifted),
        .readback_crc  (readback_crc)
    );

    // ---------------- chain model ----------------
    logic [CL-1:0] chain = '0;
    assign ccff_tail = chain[CL-1];
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
    end

    // ---------------- scoreboard ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    logic [0:0] exp_q[$];
    int   shift_cnt, ready_cnt, hs_cnt, stall_cnt, run_len, max_run;
    logic last_head = 1'b0;
    bit   mon_en    = 1'b0;
    logic [CL-1:0] snap;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc_of(input logic [CL-1:0] c);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        for (int i = CL - 1; i >= 0; i--) begin
            fb = r[15] ^ c[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction

    // Samples just after the falling edge: outputs are settled and inputs
    // already hold what the next rising edge will see.
    always begin
        @(negedge prog_clk);
        #1;
        if (mon_en) begin
            if (cfg_ready) ready_cnt++;
            if (cfg_ready && cfg_valid) hs_cnt++;
            if (ccff_shift_en) begin
                shift_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                check("head_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("head_bit", ccff_head, exp_q.pop_front());
                last_head = ccff_head;
            end else begin
                run_len = 0;
                if (busy && bits_shifted != '0) begin
                    stall_cnt++;
                    check("stall_hold", ccff_head, last_head);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clr_mon();
        exp_q.delete();
        shift_cnt = 0; ready_cnt = 0; hs_cnt = 0;
        stall_cnt = 0; run_len = 0; max_run = 0;
    endtask

    task automatic push_bits(input logic [DW-1:0] w, input int n);
        for (int i = DW - 1; i > DW - 1 - n; i--) exp_q.push_back(w[i]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
    endtask

    // gap: cycles cfg_valid stays low after cfg_ready rises; hold: keep
    // cfg_valid high after the transfer.
    task automatic send_word(input logic [DW-1:0] d, input int gap, input bit hold);
        int t;
        cfg_data  = d;
        cfg_valid = (gap == 0);
        t = 0;
        while (!cfg_ready && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        check("ready_timeout", 32'(t < 100), 32'd1);
        if (gap > 0) begin
            repeat (gap) @(negedge prog_clk);
            cfg_valid = 1'b1;
        end
        @(negedge prog_clk);
        if (!hold) cfg_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        check("done_timeout", 32'(t < 200), 32'd1);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"},    cfg_ready,     0);
        check({pfx, "_head"},     ccff_head,     0);
        check({pfx, "_shift_en"}, ccff_shift_en, 0);
        check({pfx, "_busy"},     busy,          0);
        check({pfx, "_done"},     done,          0);
        check({pfx, "_bits"},     bits_shifted,  0);
        check({pfx, "_crc"},      readback_crc,  32'hFFFF);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        @(negedge prog_clk);
        check_reset_outputs("rst");
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
        mon_en = 1'b1;

        // Gapless load: A5 then 3F with cfg_valid held high.
        clr_mon();
        push_bits(8'hA5, 8);
        push_bits(8'h3F, 4);
        snap = chain;
        pulse_start();
        check("t1_busy", busy, 1);
        check("t1_bits0", bits_shifted, 0);
        send_word(8'hA5, 0, 1'b1);
        send_word(8'h3F, 0, 1'b1);
        wait_done();
        cfg_valid = 1'b0;
        check("t1_done", done, 1);
        check("t1_busy_lo", busy, 0);
        check("t1_shift_en_lo", ccff_shift_en, 0);
        check("t1_bits", bits_shifted, 12);
        check("t1_shift_edges", shift_cnt, 12);
        check("t1_max_run", max_run, 12);
        check("t1_handshakes", hs_cnt, 2);
        check("t1_ready_cycles", ready_cnt, 2);
        check("t1_stalls", stall_cnt, 0);
        check("t1_bits_left", exp_q.size(), 0);
        check("t1_crc_const", readback_crc, 32'hFECE);
        check("t1_crc_model", readback_crc, crc_of(snap));
        @(negedge prog_clk);
        check("t1_crc_stable", readback_crc, 32'hFECE);
        check("t1_done_held", done, 1);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        check("t1_abort_done", done, 0);
        check("t1_abort_busy", busy, 0);

        // Three-cycle gap between the two words.
        clr_mon();
        push_bits(8'hA5, 8);
        push_bits(8'h3F, 4);
        snap = chain;
        pulse_start();
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h3F, 3, 1'b0);
        wait_done();
        check("t2_done", done, 1);
        check("t2_shift_edges", shift_cnt, 12);
        check("t2_stalls", stall_cnt, 3);
        check("t2_handshakes", hs_cnt, 2);
        check("t2_bits", bits_shifted, 12);
        check("t2_bits_left", exp_q.size(), 0);
        check("t2_crc_model", readback_crc, crc_of(snap));

        // Abort after five shifts.
        clr_mon();
        push_bits(8'hA5, 8);
        push_bits(8'h3F, 4);
        pulse_start();
        send_word(8'hA5, 0, 1'b0);
        for (int t = 0; t < 50 && bits_shifted != 5; t++) @(negedge prog_clk);
        check("t3_reach5", bits_shifted, 5);
        abort = 1'b1;
        @(negedge prog_clk);
        abort = 1'b0;
        check("t3_busy", busy, 0);
        check("t3_shift_en", ccff_shift_en, 0);
        check("t3_done", done, 0);
        check("t3_ready", cfg_ready, 0);
        check("t3_bits", bits_shifted, 5);
        check("t3_shift_edges", shift_cnt, 5);
        cfg_data  = 8'hFF;
        cfg_valid = 1'b1;
        @(negedge prog_clk);
        check("t3_idle_ready", cfg_ready, 0);
        cfg_valid = 1'b0;
        @(negedge prog_clk);
        check("t3_bits_hold", bits_shifted, 5);
        check("t3_shift_en_hold", ccff_shift_en, 0);

        // Asynchronous reset in the middle of a load.
        clr_mon();
        push_bits(8'hA5, 8);
        push_bits(8'h3F, 4);
        pulse_start();
        send_word(8'hA5, 0, 1'b0);
        @(negedge prog_clk);
        @(negedge prog_clk);
        check("t4_pre_busy", busy, 1);
        #2;
        prog_reset_n = 1'b0;
        #1;
        check_reset_outputs("t4_rst");
        @(negedge prog_clk);
        prog_reset_n = 1'b1;
        @(negedge prog_clk);

        // Full load after reset, with a start pulse mid-load that is ignored.
        clr_mon();
        push_bits(8'hA5, 8);
        push_bits(8'h3F, 4);
        snap = chain;
        pulse_start();
        send_word(8'hA5, 0, 1'b0);
        start = 1'b1;
        @(negedge prog_clk);
        start = 1'b0;
        check("t4_start_ign_busy", busy, 1);
        check("t4_start_ign_bits", bits_shifted, 2);
        send_word(8'h3F, 0, 1'b0);
        wait_done();
        check("t4_done", done, 1);
        check("t4_bits", bits_shifted, 12);
        check("t4_shift_edges", shift_cnt, 12);
        check("t4_bits_left", exp_q.size(), 0);
        check("t4_crc_model", readback_crc, crc_of(snap));

        // Restart straight from DONE.
        clr_mon();
        push_bits(8'hA5, 8);
        push_bits(8'h3F, 4);
        snap = chain;
        pulse_start();
        check("t5_done_fall", done, 0);
        check("t5_busy", busy, 1);
        check("t5_bits0", bits_shifted, 0);
        check("t5_crc_init", readback_crc, 32'hFFFF);
        send_word(8'hA5, 0, 1'b0);
        send_word(8'h3F, 0, 1'b0);
        wait_done();
        check("t5_shift_edges", shift_cnt, 12);
        check("t5_bits", bits_shifted, 12);
        check("t5_crc_model", readback_crc, crc_of(snap));

        @(negedge prog_clk);
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Configuration-chain loader that sits directly upstream of an I/O grid tile's configuration chain.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first onto the chain head, driving a shift enable for exactly CHAIN_LEN shifts.
- Computes a CRC-16 over the bits the chain shifts out of its tail, which is the previous configuration, for readback checking.

Parameters:
- DATA_W, 32, width of incoming bitstream words (>=2).
- CHAIN_LEN, 16, number of configuration bits in the downstream chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), derived, width of the shifted-bit counter.

Ports:
- prog_clk  input  1  configuration clock; the only clock.
- prog_reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- abort  input  1  pulse that terminates a load and returns to IDLE.
- cfg_data  input  DATA_W  bitstream word; bit DATA_W-1 is shifted first.
- cfg_valid  input  1  cfg_data is valid.
- cfg_ready  output  1  loader accepts cfg_data this cycle.
- ccff_head  output  1  serial bit to the chain head; registered.
- ccff_shift_en  output  1  chain shift enable; registered. The chain captures ccff_head on each prog_clk edge where this is 1.
- ccff_tail  input  1  serial bit out of the chain tail.
- busy  output  1  state is LOAD.
- done  output  1  high in DONE.
- bits_shifted  output  CNT_W  count of bits presented on ccff_head in the current load.
- readback_crc  output  16  CRC-16 of the tail bits sampled in the current load.

Behaviour:
- Reset (prog_reset_n low, asynchronous): state=IDLE, cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, done=0, bits_shifted=0, readback_crc=16'hFFFF, word buffer empty. Reset during LOAD aborts immediately; chain contents are undefined afterwards.
- States:
  - IDLE: start -> LOAD. On that edge, clear bits_shifted, set readback_crc=FFFF, empty the buffer, clear done.
  - LOAD: stays in LOAD until CHAIN_LEN bits have been presented and the final shift edge has occurred, then -> DONE.
  - DONE: done=1 held. start -> LOAD, with the same clearing as from IDLE.
  - abort in LOAD or DONE -> IDLE. On that edge ccff_shift_en<=0 and done<=0. abort has priority over start and over a handshake in the same cycle.
- Buffer: holds buf_cnt bits remaining after the bit currently on ccff_head.
- cfg_ready = (state==LOAD) && buf_cnt==0 && bits_shifted<CHAIN_LEN. It is combinational from state only, with no dependence on cfg_valid.
- Accept edge (cfg_valid && cfg_ready):
  - ccff_head<=cfg_data[DATA_W-1], ccff_shift_en<=1.
  - Buffer<=cfg_data[DATA_W-2:0], buf_cnt<=DATA_W-1.
  - bits_shifted++.
- Each LOAD edge with buf_cnt>0 and bits_shifted<CHAIN_LEN: present the next buffered bit MSB-first, ccff_shift_en<=1, buf_cnt--, bits_shifted++.
- Gapless operation: a new word presented while the last bit of the previous word is on ccff_head yields a contiguous shift stream.
- Stall: LOAD with no bit available (buf_cnt==0, no handshake, bits_shifted<CHAIN_LEN) -> ccff_shift_en<=0 and ccff_head holds its value. No shift occurs and nothing is counted.
- Termination:
  - When bits_shifted reaches CHAIN_LEN, remaining buffered bits are discarded and buf_cnt<=0.
  - The next edge performs the final shift with ccff_shift_en still 1. That edge sets ccff_shift_en<=0, state<=DONE, done<=1.
  - Exactly CHAIN_LEN edges see ccff_shift_en=1 per completed load.
- CRC: on every edge where ccff_shift_en==1, sample ccff_tail:
  - fb = crc[15]^tail; crc <= {crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0).
  - Non-reflected, no final XOR.
  - readback_crc is stable in DONE.
- start while in LOAD is ignored. cfg_valid outside LOAD is ignored, with cfg_ready=0.

Test Plan:
- DATA_W=8, CHAIN_LEN=12. start, then words 8'hA5, 8'h3F with cfg_valid held high -> ccff_head over the 12 shift edges = 1,0,1,0,0,1,0,1,0,0,1,1. ccff_shift_en is high 12 consecutive cycles. cfg_ready is high for exactly 2 handshakes. Low 4 bits of 8'h3F are discarded. done=1 on the edge after the 12th shift. bits_shifted=12.
- Same run with ccff_tail tied 0 -> readback_crc=16'hFECE in DONE.
- Insert a 3-cycle cfg_valid gap between the two words -> ccff_shift_en low exactly 3 cycles, ccff_head holds 1 during the gap, bit sequence unchanged, total shift edges=12.
- Assert abort after 5 shifts -> next edge: IDLE, ccff_shift_en=0, done=0, cfg_ready=0. bits_shifted remains 5 until the next start.
- Drop prog_reset_n asynchronously mid-LOAD -> all outputs immediately at reset values, readback_crc=16'hFFFF. After release, a new start performs a full 12-bit load.
- start pulse during LOAD is ignored; start in DONE restarts: done falls, bits_shifted=0, readback_crc=16'hFFFF.
